// File: rtl/burst_initiator.sv
// rtl/burst_initiator.sv - strided burst master for the burst SRAM datapath; BURST_BOUNDARY_CHK_EN enables the address-overflow check
module burst_initiator #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int STRIDE_LEN = 4,
    parameter int LEN_WIDTH  = 5,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [STRIDE_LEN-1:0] req_stride,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wdata_valid,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_ready,
    output logic                  rdata_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  err,
    output logic                  burst_en,
    output logic [ADDR_WIDTH-1:0] addr_top,
    output logic                  wren,
    output logic                  rden,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RD_DRAIN,
        S_DONE
    } state_t;

    localparam logic [RD_LATENCY-1:0] PIPE_TOP = RD_LATENCY'(1) << (RD_LATENCY - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [STRIDE_LEN-1:0]   stride_q;
    logic [LEN_WIDTH-1:0]    beats_left;
    logic [RD_LATENCY-1:0]   rd_pipe;
    logic                    accept;
    logic                    beat;
    logic                    boundary_err;
    logic                    pipe_lower_busy;

    assign accept = req_valid && (state == S_IDLE);
    assign beat   = ((state == S_WR) && wdata_valid) || (state == S_RD);

    // Only the newest entries matter for draining: the oldest is on rdata_valid now.
    assign pipe_lower_busy = |(rd_pipe & ~PIPE_TOP);

    assign rdata_valid = rd_pipe[RD_LATENCY-1];
    assign rdata       = rdata_valid ? rd_data : '0;

`ifdef BURST_BOUNDARY_CHK_EN
    localparam int SUM_W = ADDR_WIDTH + LEN_WIDTH + STRIDE_LEN;
    logic [SUM_W-1:0] last_addr;
    logic             err_q;

    assign last_addr    = SUM_W'(req_addr) + SUM_W'(req_len) * SUM_W'(req_stride);
    assign boundary_err = |last_addr[SUM_W-1:ADDR_WIDTH];
    assign err          = done && err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= boundary_err;
        end
    end
`else
    assign boundary_err = 1'b0;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cur_addr   <= '0;
            stride_q   <= '0;
            beats_left <= '0;
            rd_pipe    <= '0;
        end else begin
            state   <= state_nxt;
            rd_pipe <= (rd_pipe << 1) | RD_LATENCY'(rden);
            if (accept) begin
                cur_addr   <= req_addr;
                stride_q   <= req_stride;
                beats_left <= req_len;
            end else if (beat) begin
                cur_addr   <= cur_addr + ADDR_WIDTH'(stride_q);
                beats_left <= beats_left - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        done        = 1'b0;
        burst_en    = 1'b0;
        addr_top    = '0;
        wren        = 1'b0;
        rden        = 1'b0;
        wr_data     = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (boundary_err) state_nxt = S_DONE;
                    else if (req_write) state_nxt = S_WR;
                    else state_nxt = S_RD;
                end
            end
            S_WR: begin
                burst_en = 1'b1;
                addr_top = cur_addr;
                if (wdata_valid) begin
                    wren        = 1'b1;
                    wdata_ready = 1'b1;
                    wr_data     = wdata;
                    if (beats_left == '0) state_nxt = S_DONE;
                end
            end
            S_RD: begin
                burst_en = 1'b1;
                rden     = 1'b1;
                addr_top = cur_addr;
                if (beats_left == '0) state_nxt = S_RD_DRAIN;
            end
            S_RD_DRAIN: begin
                if (!pipe_lower_busy) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_burst_initiator.sv
// tb/tb_burst_initiator.sv - scoreboard bench for burst_initiator with an SRAM model and a reference memory
module tb_burst_initiator;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int LW  = 5;
    localparam int RDL = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [SW-1:0] req_stride;
    logic [LW-1:0] req_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          rdata_valid;
    logic [DW-1:0] rdata;
    logic          done, err, burst_en, wren, rden;
    logic [AW-1:0] addr_top;
    logic [DW-1:0] wr_data, rd_data;

    always #5 clk = ~clk;

    burst_initiator #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRIDE_LEN(SW), .LEN_WIDTH(LW), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_stride(req_stride), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
        .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err),
        .burst_en(burst_en), .addr_top(addr_top), .wren(wren), .rden(rden),
        .wr_data(wr_data), .rd_data(rd_data)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM seen by the DUT: synchronous write, read data RDL cycles after the rden address
    logic          mem_clr;
    logic [DW-1:0] mem [256];
    logic [AW-1:0] apipe [RDL];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            for (int i = 0; i < RDL; i++) apipe[i] <= '0;
        end else begin
            if (wren) mem[addr_top] <= wr_data;
            apipe[0] <= addr_top;
            for (int i = 1; i < RDL; i++) apipe[i] <= apipe[i-1];
        end
    end
    assign rd_data = mem[apipe[RDL-1]];

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;
    typedef struct {
        int   cyc;
        logic err;
    } done_t;

    beat_t         exp_beats[$];
    logic [DW-1:0] exp_rd[$];
    done_t         exp_done[$];
    logic [DW-1:0] ref_mem [256];

    int   n_checks = 0;
    int   n_err    = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;
    int   last_acc = 0;
    int   expect_acc = -1;
    logic mon_en = 1'b1;
    logic hold_req = 1'b0;
    logic          nxt_write;
    logic [AW-1:0] nxt_addr;
    logic [SW-1:0] nxt_stride;
    logic [LW-1:0] nxt_len;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents a beat, read data or done
    initial begin
        beat_t b;
        done_t d;
        forever begin
            @(negedge clk);
            if (!rst && mon_en) begin
                if (wren || rden) begin
                    chk("burst_en_on_beat", burst_en, 1);
                    if (exp_beats.size() == 0) fail_now("unexpected_beat");
                    else begin
                        b = exp_beats.pop_front();
                        chk("beat_kind", wren, b.wr);
                        chk("beat_addr", addr_top, b.addr);
                        if (b.wr) chk("wr_data", wr_data, b.data);
                    end
                end
                if (wren || wdata_ready) chk("wdata_ready", wdata_ready, wren);
                if (rdata_valid) begin
                    if (exp_rd.size() == 0) fail_now("unexpected_rdata_valid");
                    else chk("rdata", rdata, exp_rd.pop_front());
                end
                if (done) begin
                    if (exp_done.size() == 0) fail_now("unexpected_done");
                    else begin
                        d = exp_done.pop_front();
                        chk("done_cycle", cyc, d.cyc);
                        chk("done_err", err, d.err);
                        chk("beats_left_at_done", exp_beats.size(), 0);
                        chk("reads_left_at_done", exp_rd.size(), 0);
                    end
                end else if (err) begin
                    fail_now("err_without_done");
                end
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic do_burst(input logic wr, input logic [AW-1:0] a, input logic [SW-1:0] s,
                            input logic [LW-1:0] len, input int stall_pct,
                            input int stall_at, input int stall_len);
        int            t, n, k, used, sd, acc, dc0;
        logic          ovf, v;
        logic [AW-1:0] ad [32];
        logic [DW-1:0] wd [32];
        done_t         d;
        @(posedge clk); #1;
        req_write = wr; req_addr = a; req_stride = s; req_len = len; req_valid = 1'b1;
        #1;
        t = 0;
        while (!req_ready && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        if (!req_ready) begin
            fail_now("req_accept_timeout");
            req_valid = 1'b0;
            return;
        end
        acc      = cyc;
        last_acc = acc;
        dc0      = done_cnt;
        if (expect_acc >= 0) chk("accept_cycle", acc, expect_acc);
        n   = int'(len) + 1;
        ovf = 1'b0;
`ifdef BURST_BOUNDARY_CHK_EN
        ovf = (int'(a) + int'(len) * int'(s)) > 255;
`endif
        for (int i = 0; i < n; i++) begin
            ad[i] = AW'(int'(a) + i * int'(s));
            wd[i] = $urandom;
            if (!ovf) begin
                if (wr) begin
                    ref_mem[ad[i]] = wd[i];
                    exp_beats.push_back({1'b1, ad[i], wd[i]});
                end else begin
                    exp_beats.push_back({1'b0, ad[i], {DW{1'b0}}});
                    exp_rd.push_back(ref_mem[ad[i]]);
                end
            end
        end
        @(posedge clk); #1;
        if (hold_req) begin
            req_write = nxt_write; req_addr = nxt_addr; req_stride = nxt_stride; req_len = nxt_len;
        end else begin
            req_valid = 1'b0;
        end
        if (ovf) begin
            d.cyc = acc + 1; d.err = 1'b1; exp_done.push_back(d);
        end else if (wr) begin
            k = 0; used = 0; sd = 0;
            while (k < n) begin
                if (k == stall_at && sd < stall_len) begin
                    v = 1'b0;
                    sd++;
                end else begin
                    v = ($urandom_range(99) >= stall_pct);
                end
                wdata_valid = v;
                wdata       = v ? wd[k] : $urandom;
                used++;
                if (!v) begin
                    #1;
                    chk("stall_addr_hold", addr_top, ad[k]);
                    chk("stall_no_wren", wren, 0);
                end
                if (v) k++;
                @(posedge clk); #1;
            end
            wdata_valid = 1'b0;
            wdata       = '0;
            d.cyc = acc + used + 1; d.err = 1'b0; exp_done.push_back(d);
        end else begin
            d.cyc = acc + n + RDL + 1; d.err = 1'b0; exp_done.push_back(d);
        end
        t = 0;
        while (done_cnt == dc0 && t < 400) begin
            @(negedge clk); #1;
            t++;
        end
        if (done_cnt == dc0) fail_now("done_timeout");
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [SW-1:0] rs;
        logic [LW-1:0] rl;
        int            dc0;
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 0; req_write = 0; req_addr = '0; req_stride = '0; req_len = '0;
        wdata_valid = 0; wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {req_ready, burst_en, wren, rden, wdata_ready, done, err, rdata_valid}, 8'b1000_0000);
        chk("reset_addr_top", addr_top, 0);
        rst = 1'b0; mem_clr = 1'b0;
        @(posedge clk); #1;
        chk("idle_flags", {req_ready, burst_en, wren, rden, wdata_ready, done, err, rdata_valid}, 8'b1000_0000);

        // Reset mid-burst at beat 2 of 4
        mon_en = 1'b0;
        req_write = 1; req_addr = 8'h40; req_stride = 4'd1; req_len = 5'd3; req_valid = 1;
        wdata_valid = 1; wdata = 32'hA0;
        @(posedge clk); #1; req_valid = 0;
        @(posedge clk); #1; wdata = 32'hA1;
        @(posedge clk); #1; wdata = 32'hA2;
        chk("pre_reset_wren", wren, 1);
        chk("pre_reset_addr", addr_top, 8'h42);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_flags", {req_ready, burst_en, wren, rden, wdata_ready, done, err, rdata_valid}, 8'b1000_0000);
        chk("async_reset_addr", addr_top, 0);
        chk("async_reset_wr_data", wr_data, 0);
        ref_mem[8'h40] = 32'hA0;
        ref_mem[8'h41] = 32'hA1;
        wdata_valid = 0;
        dc0 = done_cnt;
        @(posedge clk); #1; rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_cnt, dc0);
        chk("ready_after_reset", req_ready, 1);
        mon_en = 1'b1;

        do_burst(1, 8'h10, 4'd4, 5'd3, 0, -1, 0);
        chk("wr_burst_latency", last_done_cyc - last_acc, 5);
        do_burst(0, 8'h10, 4'd4, 5'd3, 0, -1, 0);
        chk("rd_burst_latency", last_done_cyc - last_acc, 4 + RDL + 1);
        do_burst(1, 8'h10, 4'd4, 5'd3, 0, 1, 2);
        chk("stalled_wr_latency", last_done_cyc - last_acc, 7);
        do_burst(0, 8'h40, 4'd1, 5'd1, 0, -1, 0);
        do_burst(0, 8'h10, 4'd4, 5'd3, 0, -1, 0);

        do_burst(1, 8'hFC, 4'd2, 5'd3, 0, -1, 0);
        do_burst(0, 8'hFC, 4'd2, 5'd3, 0, -1, 0);

        // Back-to-back: second request held valid across the first burst
        hold_req = 1'b1;
        nxt_write = 1; nxt_addr = 8'h33; nxt_stride = 4'd0; nxt_len = 5'd4;
        do_burst(0, 8'h10, 4'd4, 5'd3, 0, -1, 0);
        hold_req = 1'b0;
        expect_acc = last_done_cyc + 1;
        do_burst(1, 8'h33, 4'd0, 5'd4, 0, -1, 0);
        expect_acc = -1;
        do_burst(0, 8'h33, 4'd0, 5'd4, 0, -1, 0);

        for (int it = 0; it < 16; it++) begin
            ra = AW'($urandom);
            rs = SW'($urandom);
            rl = LW'($urandom);
            do_burst(1, ra, rs, rl, $urandom_range(40), -1, 0);
            do_burst(0, ra, rs, rl, 0, -1, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("final_idle", req_ready, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
